// File: rtl/bin_decode_renorm.sv
// Binary arithmetic bin decoder with range renormalisation.
// Loads a 9-bit offset on init, decodes one bin per accepted request from the
// upstream LPS sub-range, then consumes renormalisation bits until range>=256.
module bin_decode_renorm #(
  parameter int RANGE_INIT = 510
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_lps,
  input  logic       req_mps,
  output logic [8:0] range_out,
  output logic       bin_out,
  output logic       bin_valid,
  input  logic       bin_ready,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, INIT, READY, RENORM, OUT} state_t;

  localparam logic [8:0] RANGE_LOAD = 9'(RANGE_INIT);

  state_t      state, state_nx;
  logic [8:0]  range_q, range_nx;
  logic [8:0]  offset, offset_nx;
  logic        bin_q, bin_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        err_q, err_nx;

  logic        bit_acc, req_acc;
  logic [8:0]  lps_ext, lps_eff, rmps, new_range, shifted;
  logic        lps_over, illegal;

  // A zero LPS sub-range would stall the engine forever; substitute 1.
  function automatic logic [8:0] sub_lps(input logic [7:0] lps);
    return (lps == 8'd0) ? 9'd1 : {1'b0, lps};
  endfunction

  // MPS sub-range; forced to 0 when the LPS range swallows the whole range so
  // the LPS path is always taken and the offset is left untouched.
  function automatic logic [8:0] mps_range(input logic [8:0] rng, input logic [8:0] lps,
                                           input logic over);
    return over ? 9'd0 : (rng - lps);
  endfunction

  // Handshakes are decoded from state only, so no input reaches an output.
  assign bit_ready = (state == INIT) || (state == RENORM);
  assign req_ready = (state == READY);
  assign bin_valid = (state == OUT);
  assign range_out = range_q;
  assign bin_out   = bin_q;
  assign err       = err_q;

  assign bit_acc   = bit_ready && bit_valid;
  assign req_acc   = req_ready && req_valid;
  assign lps_ext   = {1'b0, req_lps};
  assign lps_eff   = sub_lps(req_lps);
  assign lps_over  = (lps_ext >= range_q);
  assign illegal   = (req_lps == 8'd0) || lps_over;
  assign rmps      = mps_range(range_q, lps_eff, lps_over);
  assign shifted   = {range_q[7:0], 1'b0};

  // Next-state and datapath update; init wins over every other transition.
  always_comb begin
    state_nx  = state;
    range_nx  = range_q;
    offset_nx = offset;
    bin_nx    = bin_q;
    cnt_nx    = cnt;
    err_nx    = err_q;
    new_range = range_q;
    if (init) begin
      state_nx  = INIT;
      range_nx  = RANGE_LOAD;
      offset_nx = 9'd0;
      cnt_nx    = 4'd0;
      err_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        INIT: begin
          if (bit_acc) begin
            offset_nx = {offset[7:0], bit_in};
            cnt_nx    = cnt + 4'd1;
            if (cnt == 4'd8) state_nx = READY;
          end
        end
        READY: begin
          if (req_acc) begin
            if (illegal) err_nx = 1'b1;
            if (offset < rmps) begin
              bin_nx    = req_mps;
              new_range = rmps;
            end else begin
              bin_nx    = ~req_mps;
              offset_nx = offset - rmps;
              new_range = lps_eff;
            end
            range_nx = new_range;
            state_nx = new_range[8] ? OUT : RENORM;
          end
        end
        RENORM: begin
          if (bit_acc) begin
            range_nx  = shifted;
            offset_nx = {offset[7:0], bit_in};
            if (shifted[8]) state_nx = OUT;
          end
        end
        OUT: begin
          if (bin_ready) state_nx = READY;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and datapath registers; rst overrides init.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      range_q <= RANGE_LOAD;
      offset  <= 9'd0;
      bin_q   <= 1'b0;
      cnt     <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      range_q <= range_nx;
      offset  <= offset_nx;
      bin_q   <= bin_nx;
      cnt     <= cnt_nx;
      err_q   <= err_nx;
    end
  end

endmodule
